// File: rtl/car_park_sensor_conditioner.sv
// car_park_sensor_conditioner
//
// Conditioning stage for the car-park bay sensors. It debounces each raw bay
// sensor, emits a one-cycle pulse on every accepted 0->1 transition, and
// keeps a saturating 16-bit total of all pulses issued since reset.
//
// Optional feature macro: CAR_PARK_SENSOR_SYNC_EN
//   defined     - each sensors_raw bit passes through a 2-flop synchronizer
//                 before the debouncer (+2 cycles latency)
//   not defined - sensors_raw feeds the debouncer directly (must already be
//                 synchronous to clk)
//
// Parameters:
//   N               number of bays (channels)
//   DEBOUNCE_CYCLES consecutive differing samples needed to accept a new level (>=1)
//
// Ports:
//   clk            clock, all state changes on rising edge
//   rst            synchronous active-high reset
//   sensors_raw    [N-1:0] raw bay sensors (1 = vehicle present)
//   sensor_pulses  [N-1:0] one-cycle pulse per bay on accepted 0->1 transition
//   sensor_stable  [N-1:0] debounced level per bay
//   event_count    [15:0]  saturating count of all pulses since reset

module car_park_sensor_conditioner #(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sensors_raw,
    output logic [N-1:0] sensor_pulses,
    output logic [N-1:0] sensor_stable,
    output logic [15:0]  event_count
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  s;
    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];
    logic [N-1:0]  stable_nxt;
    logic [N-1:0]  rise;
    logic [15:0]   pc;
    logic [16:0]   sum;
    logic [15:0]   count_nxt;

`ifdef CAR_PARK_SENSOR_SYNC_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensors_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = sensors_raw;
`endif

    // Any sample matching the stable level clears progress, so a single
    // bounce restarts the debounce window from zero.
    always_comb begin
        stable_nxt = sensor_stable;
        rise       = '0;
        pc         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != sensor_stable[i]) begin
                if (cnt[i] == LAST) begin
                    stable_nxt[i] = s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise = stable_nxt & ~sensor_stable;
        for (int unsigned i = 0; i < N; i++) begin
            pc = pc + 16'(rise[i]);
        end
        sum       = {1'b0, event_count} + {1'b0, pc};
        count_nxt = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            sensor_stable <= '0;
            sensor_pulses <= '0;
            event_count   <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sensor_stable <= stable_nxt;
            sensor_pulses <= rise;
            event_count   <= count_nxt;
        end
    end

endmodule

// File: tb/tb_car_park_sensor_conditioner.sv
// Directed testbench for car_park_sensor_conditioner in its default build
// (N=8, DEBOUNCE_CYCLES=4, synchronizer macro undefined).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.

module tb_car_park_sensor_conditioner;

    logic        clk;
    logic        rst;
    logic [7:0]  sensors_raw;
    logic [7:0]  sensor_pulses;
    logic [7:0]  sensor_stable;
    logic [15:0] event_count;

    int unsigned total;
    int unsigned bad;

    car_park_sensor_conditioner #(
        .N               (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensors_raw   (sensors_raw),
        .sensor_pulses (sensor_pulses),
        .sensor_stable (sensor_stable),
        .event_count   (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sensors_raw = 8'h00;
        tick();
        chk("rst_count", 32'(event_count), 32'h0);
        chk("rst_stable", 32'(sensor_stable), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        sensors_raw = 8'hFF;

        // Reset held with all sensors high: everything stays clear.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_pulses", 32'(sensor_pulses), 32'h0);
            chk("rst_hold_stable", 32'(sensor_stable), 32'h0);
            chk("rst_hold_count",  32'(event_count),   32'h0);
        end
        rst = 1'b0;
        // Debounce starts fresh after release: pulse after the 4th edge.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rel_nopulse", 32'(sensor_pulses), 32'h0);
        end
        tick();
        chk("rst_rel_pulse",  32'(sensor_pulses), 32'hFF);
        chk("rst_rel_stable", 32'(sensor_stable), 32'hFF);
        chk("rst_rel_count",  32'(event_count),   32'd8);
        tick();
        chk("rst_rel_clear",  32'(sensor_pulses), 32'h0);

        // Clean arrival on bay 2.
        do_reset();
        sensors_raw = 8'h04;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arr_wait_stable", 32'(sensor_stable), 32'h0);
            chk("arr_wait_pulse",  32'(sensor_pulses), 32'h0);
        end
        tick();
        chk("arr_stable", 32'(sensor_stable), 32'h04);
        chk("arr_pulse",  32'(sensor_pulses), 32'h04);
        chk("arr_count",  32'(event_count),   32'd1);
        tick();
        chk("arr_pulse_clr", 32'(sensor_pulses), 32'h0);
        chk("arr_count_hold", 32'(event_count),  32'd1);

        // Bounce on bay 0: 1,1,1,0,1,1,1,1 -> pulse only after the last sample.
        do_reset();
        begin
            logic [7:0] pat;
            pat = 8'b1111_0111; // bit k = sample at edge k
            for (int k = 0; k < 8; k++) begin
                sensors_raw = {7'b0, pat[k]};
                tick();
                if (k < 7) begin
                    chk("bnc_nopulse", 32'(sensor_pulses), 32'h0);
                    chk("bnc_stable0", 32'(sensor_stable), 32'h0);
                end
            end
        end
        chk("bnc_pulse", 32'(sensor_pulses), 32'h01);
        chk("bnc_count", 32'(event_count),   32'd1);
        tick();
        chk("bnc_clr",   32'(sensor_pulses), 32'h0);
        chk("bnc_count_hold", 32'(event_count), 32'd1);

        // Reset mid-debounce discards partial progress.
        do_reset();
        sensors_raw = 8'h01;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_pulse", 32'(sensor_pulses), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_nopulse", 32'(sensor_pulses), 32'h0);
        end
        tick();
        chk("midrst_pulse_late", 32'(sensor_pulses), 32'h01);
        chk("midrst_count",      32'(event_count),   32'd1);

        // Simultaneous arrivals.
        do_reset();
        sensors_raw = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sim_nopulse", 32'(sensor_pulses), 32'h0);
        end
        tick();
        chk("sim_pulse", 32'(sensor_pulses), 32'hA5);
        chk("sim_count", 32'(event_count),   32'd4);
        tick();
        chk("sim_clr",   32'(sensor_pulses), 32'h0);

        // Departure of bay 5: stable drops after 4 samples, no pulse.
        sensors_raw = 8'h85;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dep_wait_stable", 32'(sensor_stable), 32'hA5);
            chk("dep_nopulse",     32'(sensor_pulses), 32'h0);
        end
        tick();
        chk("dep_stable",  32'(sensor_stable), 32'h85);
        chk("dep_nopulse", 32'(sensor_pulses), 32'h0);
        chk("dep_count",   32'(event_count),   32'd4);
        // Re-arrival of bay 5 after minimum spacing.
        sensors_raw = 8'hA5;
        repeat (3) tick();
        tick();
        chk("rearr_pulse", 32'(sensor_pulses), 32'h20);
        chk("rearr_count", 32'(event_count),   32'd5);

        // Saturation: 8191 rounds of 8 arrivals -> 16'hFFF8.
        do_reset();
        for (int r = 0; r < 8191; r++) begin
            sensors_raw = 8'hFF;
            repeat (4) tick();
            sensors_raw = 8'h00;
            repeat (4) tick();
        end
        chk("sat_preload", 32'(event_count), 32'hFFF8);
        sensors_raw = 8'h3F;
        repeat (4) tick();
        chk("sat_fffe", 32'(event_count), 32'hFFFE);
        sensors_raw = 8'h00;
        repeat (4) tick();
        sensors_raw = 8'h03;
        repeat (4) tick();
        chk("sat_pulse", 32'(sensor_pulses), 32'h03);
        chk("sat_ffff",  32'(event_count),   32'hFFFF);
        sensors_raw = 8'h00;
        repeat (4) tick();
        sensors_raw = 8'hFF;
        repeat (4) tick();
        chk("sat_hold_pulse", 32'(sensor_pulses), 32'hFF);
        chk("sat_hold",       32'(event_count),   32'hFFFF);
        tick();
        chk("sat_hold2",      32'(event_count),   32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
